bht_update_ctrl: RTL and testbench

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

---
 rtl/bht_update_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bht_update_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl
//   Sits between branch resolution in EX and the BHT write port. Resolved
//   branches and jumps go into a small FIFO. The FIFO drains one entry per
//   cycle as a 2-bit saturating-counter update. After reset (INIT) and after
//   a flush request (CLEAR), the controller sweeps the whole table and writes
//   every entry to weakly-not-taken (2'b01). While a sweep runs, the FIFO
//   keeps accepting entries but is not drained.
//
//   Handshake: a resolution is taken on any rising edge where
//   resolve_valid && resolve_ready. resolve_ready is simply !full, so it does
//   not depend on resolve_valid. An accepted resolution with neither branch
//   nor jump set is consumed but not queued.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   resolve_valid/resolve_ready  resolution handshake
//   resolve_index                BHT index of the resolved instruction
//   branch, jump, br_en          control-flow type and branch outcome
//   pred_state                   counter value read at fetch time
//   flush_req                    one-cycle pulse: discard queue, re-sweep table
//   bht_load/windex/datain       registered BHT write port
//   busy                         high while sweeping (INIT or CLEAR)
//   count                        queue occupancy
//   dbg_state                    current FSM state (0=INIT, 1=RUN, 2=CLEAR)
module bht_update_ctrl #(
    parameter int S_INDEX = 10,
    parameter int DEPTH   = 4,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               resolve_valid,
    output logic               resolve_ready,
    input  logic [S_INDEX-1:0] resolve_index,
    input  logic               branch,
    input  logic               jump,
    input  logic               br_en,
    input  logic [1:0]         pred_state,
    input  logic               flush_req,
    output logic               bht_load,
    output logic [S_INDEX-1:0] bht_windex,
    output logic [1:0]         bht_datain,
    output logic               busy,
    output logic [PW:0]        count,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Queue entry layout: {index, taken, pred_state}
    localparam int EW = S_INDEX + 3;

    state_t             state_q, state_d;
    logic [S_INDEX-1:0] sweep_q, sweep_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]        count_q, count_d;
    logic               load_q, load_d;
    logic [S_INDEX-1:0] windex_q, windex_d;
    logic [1:0]         datain_q, datain_d;
    logic [EW-1:0]      mem_q [DEPTH];

    logic               full;
    logic               push;
    logic               pop;
    logic [EW-1:0]      head;
    logic               head_taken;
    logic [1:0]         head_pred;
    logic [1:0]         head_next;

    assign full          = (count_q == (PW+1)'(DEPTH));
    assign resolve_ready = !full;
    // A flush discards any push that arrives in the same cycle.
    assign push = resolve_valid && resolve_ready && (branch || jump) && !flush_req;

    assign head       = mem_q[rd_ptr_q];
    assign head_taken = head[2];
    assign head_pred  = head[1:0];

    always_comb begin
        head_next = head_pred;
        if (head_taken) begin
            if (head_pred != 2'd3) head_next = head_pred + 2'd1;
        end else begin
            if (head_pred != 2'd0) head_next = head_pred - 2'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        load_d   = 1'b0;
        windex_d = windex_q;
        datain_d = datain_q;
        pop      = 1'b0;
        if (flush_req) begin
            state_d = CLEAR;
            sweep_d = '0;
        end else begin
            case (state_q)
                INIT, CLEAR: begin
                    load_d   = 1'b1;
                    windex_d = sweep_q;
                    datain_d = 2'b01;
                    sweep_d  = sweep_q + 1'b1;
                    if (sweep_q == {S_INDEX{1'b1}}) state_d = RUN;
                end
                RUN: begin
                    if (count_q != '0) begin
                        pop      = 1'b1;
                        load_d   = 1'b1;
                        windex_d = head[EW-1:3];
                        datain_d = head_next;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_req) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            sweep_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            load_q   <= 1'b0;
            windex_q <= '0;
            datain_q <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            load_q   <= load_d;
            windex_q <= windex_d;
            datain_q <= datain_d;
        end
    end

    // Queue storage is not reset. An entry is read only after it has been
    // written, because count_q gates every pop.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {resolve_index, (br_en || jump), pred_state};
    end

    assign bht_load   = load_q;
    assign bht_windex = windex_q;
    assign bht_datain = datain_q;
    assign busy       = (state_q != RUN);
    assign count      = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bht_update_ctrl.sv
module tb_bht_update_ctrl;

  logic       clk;
  logic       rst_n;
  logic       resolve_valid;
  logic       resolve_ready;
  logic [2:0] resolve_index;
  logic       branch;
  logic       jump;
  logic       br_en;
  logic [1:0] pred_state;
  logic       flush_req;
  logic       bht_load;
  logic [2:0] bht_windex;
  logic [1:0] bht_datain;
  logic       busy;
  logic [2:0] count;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  bht_update_ctrl #(.S_INDEX(3), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .resolve_valid (resolve_valid),
    .resolve_ready (resolve_ready),
    .resolve_index (resolve_index),
    .branch        (branch),
    .jump          (jump),
    .br_en         (br_en),
    .pred_state    (pred_state),
    .flush_req     (flush_req),
    .bht_load      (bht_load),
    .bht_windex    (bht_windex),
    .bht_datain    (bht_datain),
    .busy          (busy),
    .count         (count),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] idx, input logic br, input logic jp,
                       input logic en, input logic [1:0] ps);
    resolve_valid = 1'b1;
    resolve_index = idx;
    branch        = br;
    jump          = jp;
    br_en         = en;
    pred_state    = ps;
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    br_en         = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", busy); end
    checks++; if (resolve_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", resolve_ready); end
    checks++; if (bht_load !== 1'b0) begin errors++; $display("FAIL reset_load got %0b want 0", bht_load); end
    checks++; if (bht_windex !== 3'd0) begin errors++; $display("FAIL reset_windex got %0d want 0", bht_windex); end
    checks++; if (bht_datain !== 2'd0) begin errors++; $display("FAIL reset_datain got %0d want 0", bht_datain); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bht_load !== 1'b1 || bht_windex !== 3'(i) || bht_datain !== 2'b01)
        begin errors++; $display("FAIL init_write[%0d] got load=%0b idx=%0d data=%0d want 1/%0d/1", i, bht_load, bht_windex, bht_datain, i); end
      checks++; if (busy !== (i < 7))
        begin errors++; $display("FAIL init_busy[%0d] got %0b want %0b", i, busy, (i < 7)); end
    end
    tick();
    checks++; if (bht_load !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL init_done got load=%0b busy=%0b want 0/0", bht_load, busy); end
  endtask

  task automatic test_saturation();
    offer(3'd5, 1'b1, 1'b0, 1'b1, 2'd3);
    tick();
    checks++; if (bht_load !== 1'b0 || count !== 3'd1)
      begin errors++; $display("FAIL sat_push got load=%0b count=%0d want 0/1", bht_load, count); end
    offer(3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    idle();
    checks++; if (bht_load !== 1'b1 || bht_windex !== 3'd5 || bht_datain !== 2'd3)
      begin errors++; $display("FAIL sat_up got load=%0b idx=%0d data=%0d want 1/5/3", bht_load, bht_windex, bht_datain); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL sat_count got %0d want 1", count); end
    tick();
    checks++; if (bht_load !== 1'b1 || bht_windex !== 3'd2 || bht_datain !== 2'd0)
      begin errors++; $display("FAIL sat_down got load=%0b idx=%0d data=%0d want 1/2/0", bht_load, bht_windex, bht_datain); end
    tick();
    checks++; if (bht_load !== 1'b0 || count !== 3'd0)
      begin errors++; $display("FAIL sat_idle got load=%0b count=%0d want 0/0", bht_load, count); end
  endtask

  task automatic test_filter();
    offer(3'd6, 1'b0, 1'b0, 1'b1, 2'd2);
    tick();
    idle();
    checks++; if (count !== 3'd0 || bht_load !== 1'b0)
      begin errors++; $display("FAIL filter_drop got count=%0d load=%0b want 0/0", count, bht_load); end
    tick();
    checks++; if (bht_load !== 1'b0) begin errors++; $display("FAIL filter_nowrite got load=%0b want 0", bht_load); end
    offer(3'd3, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    idle();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL filter_jump_count got %0d want 1", count); end
    tick();
    checks++; if (bht_load !== 1'b1 || bht_windex !== 3'd3 || bht_datain !== 2'd2)
      begin errors++; $display("FAIL filter_jump got load=%0b idx=%0d data=%0d want 1/3/2", bht_load, bht_windex, bht_datain); end
  endtask

  task automatic test_full();
    logic [2:0] e_idx [4];
    logic [1:0] e_dat [4];
    logic [2:0] p_idx [4];
    logic       p_tk  [4];
    logic [1:0] p_ps  [4];
    p_idx[0] = 3'd1; p_tk[0] = 1'b1; p_ps[0] = 2'd1; e_idx[0] = 3'd1; e_dat[0] = 2'd2;
    p_idx[1] = 3'd4; p_tk[1] = 1'b0; p_ps[1] = 2'd2; e_idx[1] = 3'd4; e_dat[1] = 2'd1;
    p_idx[2] = 3'd7; p_tk[2] = 1'b1; p_ps[2] = 2'd0; e_idx[2] = 3'd7; e_dat[2] = 2'd1;
    p_idx[3] = 3'd0; p_tk[3] = 1'b0; p_ps[3] = 2'd3; e_idx[3] = 3'd0; e_dat[3] = 2'd2;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      offer(p_idx[i], 1'b1, 1'b0, p_tk[i], p_ps[i]);
      tick();
      checks++; if (bht_windex !== 3'(i) || bht_datain !== 2'b01)
        begin errors++; $display("FAIL full_sweep[%0d] got idx=%0d data=%0d want %0d/1", i, bht_windex, bht_datain, i); end
    end
    checks++; if (count !== 3'd4 || resolve_ready !== 1'b0)
      begin errors++; $display("FAIL full_state got count=%0d ready=%0b want 4/0", count, resolve_ready); end
    offer(3'd6, 1'b1, 1'b0, 1'b1, 2'd2);
    tick();
    idle();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject got count=%0d want 4", count); end
    for (int i = 5; i < 8; i++) tick();
    checks++; if (bht_windex !== 3'd7 || count !== 3'd4)
      begin errors++; $display("FAIL full_sweep_end got idx=%0d count=%0d want 7/4", bht_windex, count); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bht_load !== 1'b1 || bht_windex !== e_idx[i] || bht_datain !== e_dat[i])
        begin errors++; $display("FAIL full_drain[%0d] got load=%0b idx=%0d data=%0d want 1/%0d/%0d", i, bht_load, bht_windex, bht_datain, e_idx[i], e_dat[i]); end
    end
    tick();
    checks++; if (bht_load !== 1'b0 || count !== 3'd0)
      begin errors++; $display("FAIL full_empty got load=%0b count=%0d want 0/0", bht_load, count); end
  endtask

  task automatic test_flush();
    pulse_reset();
    offer(3'd2, 1'b1, 1'b0, 1'b1, 2'd0); tick();
    offer(3'd3, 1'b1, 1'b0, 1'b1, 2'd0); tick();
    offer(3'd5, 1'b1, 1'b0, 1'b1, 2'd0); tick();
    idle();
    tick();
    checks++; if (count !== 3'd3 || bht_windex !== 3'd3)
      begin errors++; $display("FAIL flush_setup got count=%0d idx=%0d want 3/3", count, bht_windex); end
    flush_req = 1'b1;
    offer(3'd6, 1'b1, 1'b0, 1'b1, 2'd1);
    tick();
    flush_req = 1'b0;
    idle();
    checks++; if (bht_load !== 1'b0 || count !== 3'd0 || busy !== 1'b1)
      begin errors++; $display("FAIL flush_cycle got load=%0b count=%0d busy=%0b want 0/0/1", bht_load, count, busy); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bht_load !== 1'b1 || bht_windex !== 3'(i) || bht_datain !== 2'b01)
        begin errors++; $display("FAIL flush_sweep[%0d] got load=%0b idx=%0d data=%0d want 1/%0d/1", i, bht_load, bht_windex, bht_datain, i); end
    end
    tick();
    checks++; if (bht_load !== 1'b0 || count !== 3'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL flush_old_gone got load=%0b count=%0d busy=%0b want 0/0/0", bht_load, count, busy); end
  endtask

  task automatic test_async_reset();
    offer(3'd1, 1'b1, 1'b0, 1'b1, 2'd1); tick();
    offer(3'd2, 1'b1, 1'b0, 1'b1, 2'd1); tick();
    offer(3'd3, 1'b1, 1'b0, 1'b1, 2'd1); tick();
    idle();
    checks++; if (bht_load !== 1'b1 || bht_windex !== 3'd2 || bht_datain !== 2'd2 || count !== 3'd1)
      begin errors++; $display("FAIL ar_drain got load=%0b idx=%0d data=%0d count=%0d want 1/2/2/1", bht_load, bht_windex, bht_datain, count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bht_load !== 1'b0 || count !== 3'd0 || busy !== 1'b1 || bht_windex !== 3'd0)
      begin errors++; $display("FAIL ar_async got load=%0b count=%0d busy=%0b idx=%0d want 0/0/1/0", bht_load, count, busy, bht_windex); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bht_load !== 1'b1 || bht_windex !== 3'(i) || bht_datain !== 2'b01)
        begin errors++; $display("FAIL ar_sweep[%0d] got load=%0b idx=%0d data=%0d want 1/%0d/1", i, bht_load, bht_windex, bht_datain, i); end
    end
    tick();
    checks++; if (bht_load !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL ar_done got load=%0b busy=%0b want 0/0", bht_load, busy); end
  endtask

  initial begin
    rst_n         = 1'b0;
    flush_req     = 1'b0;
    resolve_index = 3'd0;
    pred_state    = 2'd0;
    idle();
    test_reset();
    test_saturation();
    test_filter();
    test_full();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
